// File: rtl/card_hand_display_pkg.sv
// Shared card types and helpers for the baccarat hand display.
// Consumers import card_pkg::*.
package card_pkg;

    typedef enum logic [3:0] {
        CARD_NONE = 4'd0,
        CARD_A    = 4'd1,
        CARD_2    = 4'd2,
        CARD_3    = 4'd3,
        CARD_4    = 4'd4,
        CARD_5    = 4'd5,
        CARD_6    = 4'd6,
        CARD_7    = 4'd7,
        CARD_8    = 4'd8,
        CARD_9    = 4'd9,
        CARD_10   = 4'd10,
        CARD_J    = 4'd11,
        CARD_Q    = 4'd12,
        CARD_K    = 4'd13
    } card_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Baccarat point value: pip cards count face value, tens and court cards count zero.
    function automatic logic [3:0] card_value(input card_t c);
        if (c >= CARD_A && c <= CARD_9) return 4'(c);
        return 4'd0;
    endfunction

    function automatic logic card_legal(input logic [3:0] code);
        return (code != 4'd0) && (code <= 4'd13);
    endfunction

endpackage

// File: rtl/card_seg_dec.sv
// Combinational card code -> active-low 7-segment pattern (gfedcba).
// Codes 0, 14 and 15 decode to a blank digit.
module card_seg_dec
    import card_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd1:    seg_o = 7'b0001000;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            4'd10:   seg_o = 7'b1000000;
            4'd11:   seg_o = 7'b1100001;
            4'd12:   seg_o = 7'b0011000;
            4'd13:   seg_o = 7'b0001001;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/card_hand_display.sv
// One baccarat hand: slot registers, fill count, lagged score and HEX drive.
// Define CARD_BLINK_EN to blink the newest card's digit every BLINK_DIV cycles.
module card_hand_display
    import card_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
`ifdef CARD_BLINK_EN
    parameter int BLINK_DIV = 25_000_000,
`endif
    localparam int CNT_W = $clog2(NUM_SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   card_valid,
    output logic                   card_ready,
    input  logic [3:0]             card_in,
    output logic                   card_err,
    output logic [7*NUM_SLOTS-1:0] hex_out,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic [3:0]             score
);

    // Handshake: a card transfers on a rising edge where card_valid && card_ready;
    // card_ready depends only on full, never on card_valid.
    logic [3:0]       slot_q [NUM_SLOTS];
    logic [3:0]       slot_d [NUM_SLOTS];
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       score_q, score_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [3:0]       pend_val_q, pend_val_d;
    logic             accept, legal;
    logic [4:0]       sum5;
    logic             blank_newest;

    assign full       = (count_q == CNT_W'(NUM_SLOTS));
    assign card_ready = !full;
    assign accept     = card_valid && card_ready;
    assign legal      = card_legal(card_in);
    assign count      = count_q;
    assign score      = score_q;
    assign card_err   = err_q;
    assign sum5       = {1'b0, score_q} + {1'b0, pend_val_q};

    always_comb begin
        slot_d     = slot_q;
        count_d    = count_q;
        score_d    = score_q;
        err_d      = 1'b0;
        pend_d     = 1'b0;
        pend_val_d = 4'd0;
        // Score trails the slot update by one cycle via the pending value.
        if (pend_q) score_d = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
        if (clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = 4'd0;
            count_d = '0;
            score_d = 4'd0;
        end else if (accept) begin
            if (legal) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (count_q == CNT_W'(i)) slot_d[i] = card_in;
                count_d    = count_q + 1'b1;
                pend_d     = 1'b1;
                pend_val_d = card_value(card_t'(card_in));
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= 4'd0;
            count_q    <= '0;
            score_q    <= 4'd0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= 4'd0;
        end else begin
            slot_q     <= slot_d;
            count_q    <= count_d;
            score_q    <= score_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

`ifdef CARD_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    // Restart on a new card so it is always shown first.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (clear || (accept && legal)) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = !blink_ph_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blank_newest = blink_ph_q && (count_q != '0);
`else
    assign blank_newest = 1'b0;
`endif

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [6:0] seg;
        card_seg_dec u_dec (.code_i(slot_q[i]), .seg_o(seg));
        assign hex_out[7*i +: 7] =
            (blank_newest && count_q == CNT_W'(i + 1)) ? SEG_BLANK : seg;
    end

endmodule
